profile_snapshot_initiator: RTL and testbench
=============================================

// Module: profile_snapshot_initiator
// PURPOSE
//  Custom-instruction (CI) initiator: drives the CI request side (start/cIn/valueA/valueB) of the profile-counter responder.
//  On a trigger it freezes the four profile counters, reads all four, then restarts them, all via CI transactions.
//  It holds the results in a 4-entry snapshot register file for a debug/host reader.
//  Sits beside the CPU as a second CI master; the CI mux arbitrates between them.
// PARAMETERS
//  customId     8'h00  CI opcode of the target profile responder, driven on ciCin
//  TIMEOUT      16     max cycles from ciStart to ciDone before abort (>=1)
//  ENABLE_MASK  4'hF   counters re-enabled after a snapshot; bit i maps to valueB[i]
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  trigger      in   1   one-cycle snapshot request; ignored while busy=1
//  ciStart      out  1   CI start, one-cycle pulse per transaction
//  ciCin        out  8   CI opcode, always customId
//  ciValueA     out  32  CI operand A: counter select in [1:0], other bits 0
//  ciValueB     out  32  CI operand B: enable [3:0], disable [7:4], clear [11:8]
//  ciDone       in   1   CI done; may assert in the same cycle as ciStart
//  ciResult     in   32  CI result, valid while ciDone=1
//  busy         out  1   snapshot sequence in progress
//  snapValid    out  1   all four entries hold data from the last completed snapshot
//  snapIndex    in   2   snapshot read select
//  snapData     out  32  snapshot entry[snapIndex], combinational read
//  errTimeout   out  1   sticky; set on CI timeout, cleared by the next accepted trigger
// BEHAVIOUR
//  Reset: all outputs 0. Entries cleared to 0. FSM in IDLE.
//  FSM states: IDLE -> FREEZE -> RD0 -> RD1 -> RD2 -> RD3 -> RESUME -> IDLE. Any state except IDLE can go -> ABORT -> IDLE.
//  Trigger accepted in IDLE only: busy=1 next cycle, snapValid=0, errTimeout=0.
//  Each non-IDLE state issues one CI transaction:
//   - ciStart=1 for exactly one cycle, with operands valid that cycle.
//   - Operands then held stable until done or timeout.
//   - ciStart is not reasserted in that state.
//  Handshake: done is ciDone=1 in the ciStart cycle or in any later cycle, up to TIMEOUT cycles after ciStart.
//   - ciDone=1 while no transaction is outstanding is ignored.
//  Operands per state:
//   - FREEZE: A=0, B=32'h000000F0.
//   - RDi: A=i, B=0; ciResult is written into entry i on ciDone.
//   - RESUME: A=0, B={ENABLE_MASK}.
//  Latency: one transaction costs (done cycle - start cycle + 1) cycles; the next state issues in the following cycle.
//   - With zero-wait done: 6 transactions -> busy=1 for 7 cycles (FREEZE through RESUME, plus IDLE return).
//  RESUME done: snapValid=1 and busy=0 in the next cycle.
//  Timeout: on the TIMEOUT-th cycle without ciDone -> ABORT.
//   - Sets errTimeout; busy drops the next cycle; snapValid stays 0.
//   - Entries already written are kept. Counters are left frozen.
//  Trigger while busy: dropped, no queuing. Trigger in the same cycle as RESUME done: dropped.
//  Reset mid-transaction: FSM returns to IDLE immediately, ciStart=0; the responder's state is not restored.
//  Timeout counter saturates and does not wrap; its width is clog2(TIMEOUT+1).
// CONFIGURATION
//  SNAP_CLEAR_EN defined: the RESUME operand B also sets clear bits, B={ENABLE_MASK,4'h0,ENABLE_MASK}. Counters restart from 0, giving per-interval deltas.
//  SNAP_CLEAR_EN undefined: clear bits are 0 and counters continue accumulating.
// STRUCTURE
//  Package profile_ci_pkg:
//   - FSM state enum.
//   - ValueB bit offsets: EN_LSB=0, DIS_LSB=4, CLR_LSB=8.
//   - Counter index constants: CNT_CYCLES=0, CNT_STALL=1, CNT_BUSIDLE=2, CNT_USER=3.
//  Sub-module ci_issue:
//   - Single-transaction engine: start pulse, operand hold, done or timeout detection, 1-cycle complete/abort strobes.
//   - The top FSM sequences ci_issue and owns the snapshot register file.
// TESTING
//  1 Zero-wait responder (done = start), trigger at t0:
//    - ciStart pulses at t1..t6; B sequence 0xF0,0,0,0,0,0x0F.
//    - snapValid=1 and busy=0 at t8.
//    - Entries equal the responder values 100, 20, 7, 3.
//  2 Responder with 3-cycle done latency:
//    - Each state holds operands 4 cycles; exactly one ciStart per state.
//    - snapData matches the model for snapIndex 0..3.
//  3 Responder never asserts done in RD2, TIMEOUT=16:
//    - errTimeout=1 at 16 cycles after that start; busy=0 the next cycle; snapValid=0.
//    - Entries 0 and 1 retained.
//  4 Trigger pulses during busy plus spurious ciDone in IDLE:
//    - No extra ciStart; sequence count stays 1.
//  5 reset=0 asserted during RD1 wait:
//    - All outputs 0 asynchronously.
//    - Next trigger runs a full clean sequence.
//  6 Build with SNAP_CLEAR_EN: RESUME B=0x00000F0F. Build without it: RESUME B=0x0000000F.

Source files
------------

// File: rtl/profile_ci_pkg.sv
// ---------------------------------------------------------------------------
// profile_ci_pkg
// Shared definitions for the profile snapshot initiator:
//   - ci_state_e : sequencing FSM states
//   - EN_LSB / DIS_LSB / CLR_LSB : field offsets inside CI operand B
//   - CNT_* : profile counter indices (operand A select / snapshot entry)
//   - ci_field() : places a 4-bit counter mask at a given operand-B offset
// ---------------------------------------------------------------------------
package profile_ci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FREEZE = 3'd1,
        ST_RD0    = 3'd2,
        ST_RD1    = 3'd3,
        ST_RD2    = 3'd4,
        ST_RD3    = 3'd5,
        ST_RESUME = 3'd6,
        ST_ABORT  = 3'd7
    } ci_state_e;

    localparam int EN_LSB  = 0;
    localparam int DIS_LSB = 4;
    localparam int CLR_LSB = 8;

    localparam logic [1:0] CNT_CYCLES  = 2'd0;
    localparam logic [1:0] CNT_STALL   = 2'd1;
    localparam logic [1:0] CNT_BUSIDLE = 2'd2;
    localparam logic [1:0] CNT_USER    = 2'd3;

    function automatic logic [31:0] ci_field(input logic [3:0] bits, input int lsb);
        return ({28'd0, bits} << lsb);
    endfunction

endpackage

// File: rtl/ci_issue.sv
// ---------------------------------------------------------------------------
// ci_issue
// Single custom-instruction transaction engine. A one-cycle 'issue' launches a
// transaction: start pulses for one cycle and the operands are captured and
// held until the next issue. Done is accepted from the start cycle onwards;
// if TIMEOUT cycles (start cycle included) pass without done the transaction
// is abandoned. complete/abort are one-cycle strobes in the deciding cycle.
// Ports:
//   clock, reset       clock, asynchronous active-low reset
//   issue              launch a transaction with op_a/op_b
//   op_a, op_b         operands to capture on issue
//   ci_done            responder done
//   start              registered CI start pulse
//   value_a, value_b   registered, held operands
//   complete, abort    outstanding transaction finished / timed out
// ---------------------------------------------------------------------------
module ci_issue #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        ci_done,
    output logic        start,
    output logic [31:0] value_a,
    output logic [31:0] value_b,
    output logic        complete,
    output logic        abort
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             start_r;
    logic             pend_r;
    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;

    // cnt_r holds the 1-based cycle number of the current wait cycle, so the
    // limit compare fires on exactly the TIMEOUT-th cycle without done.
    assign complete = pend_r & ci_done;
    assign abort    = pend_r & ~ci_done & (cnt_r >= CNT_LIMIT);
    assign start    = start_r;
    assign value_a  = a_r;
    assign value_b  = b_r;

    // Start pulse, operand capture, outstanding flag and saturating wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_r <= 1'b0;
            pend_r  <= 1'b0;
            cnt_r   <= '0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
        end else begin
            start_r <= issue;
            if (issue) begin
                // A new issue wins over the completion of the previous one.
                a_r    <= op_a;
                b_r    <= op_b;
                pend_r <= 1'b1;
                cnt_r  <= CNT_ONE;
            end else if (complete || abort) begin
                pend_r <= 1'b0;
                cnt_r  <= '0;
            end else if (pend_r && (cnt_r != CNT_LIMIT)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: rtl/profile_snapshot_initiator.sv
// ---------------------------------------------------------------------------
// profile_snapshot_initiator
// Second CI master beside the CPU. On trigger it freezes the four profile
// counters, reads them into a 4-entry snapshot file, then re-enables them.
// Sequence: IDLE -> FREEZE -> RD0..RD3 -> RESUME -> IDLE, any active state
// may divert to ABORT on a CI timeout.
// Optional build macro SNAP_CLEAR_EN: RESUME also clears the re-enabled
// counters so each snapshot reads a per-interval delta.
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   trigger             snapshot request, ignored while busy
//   ciStart/ciCin       CI start pulse / opcode (customId)
//   ciValueA/ciValueB   CI operands (counter select / en,dis,clr masks)
//   ciDone/ciResult     CI responder done and result
//   busy                sequence in progress
//   snapValid           snapshot file holds a complete snapshot
//   snapIndex/snapData  combinational snapshot read port
//   errTimeout          sticky CI timeout flag, cleared by accepted trigger
// ---------------------------------------------------------------------------
module profile_snapshot_initiator
    import profile_ci_pkg::*;
#(
    parameter logic [7:0] customId    = 8'h00,
    parameter int         TIMEOUT     = 16,
    parameter logic [3:0] ENABLE_MASK = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    output logic        ciStart,
    output logic [7:0]  ciCin,
    output logic [31:0] ciValueA,
    output logic [31:0] ciValueB,
    input  logic        ciDone,
    input  logic [31:0] ciResult,
    output logic        busy,
    output logic        snapValid,
    input  logic [1:0]  snapIndex,
    output logic [31:0] snapData,
    output logic        errTimeout
);

    localparam logic [31:0] FREEZE_B = ci_field(4'hF, DIS_LSB);
`ifdef SNAP_CLEAR_EN
    localparam logic [31:0] RESUME_B = ci_field(ENABLE_MASK, EN_LSB) | ci_field(ENABLE_MASK, CLR_LSB);
`else
    localparam logic [31:0] RESUME_B = ci_field(ENABLE_MASK, EN_LSB);
`endif

    ci_state_e   state_r;
    logic        busy_r;
    logic        snap_valid_r;
    logic        err_timeout_r;
    logic [31:0] snap_r [4];

    logic        issue_s;
    logic [31:0] nxt_a_s;
    logic [31:0] nxt_b_s;
    logic        complete_s;
    logic        abort_s;

    ci_issue #(
        .TIMEOUT (TIMEOUT)
    ) u_issue (
        .clock    (clock),
        .reset    (reset),
        .issue    (issue_s),
        .op_a     (nxt_a_s),
        .op_b     (nxt_b_s),
        .ci_done  (ciDone),
        .start    (ciStart),
        .value_a  (ciValueA),
        .value_b  (ciValueB),
        .complete (complete_s),
        .abort    (abort_s)
    );

    assign ciCin      = customId;
    assign busy       = busy_r;
    assign snapValid  = snap_valid_r;
    assign errTimeout = err_timeout_r;
    assign snapData   = snap_r[snapIndex];

    // Launch the next state's transaction in the cycle the current one completes.
    always_comb begin
        issue_s = 1'b0;
        nxt_a_s = 32'd0;
        nxt_b_s = 32'd0;
        case (state_r)
            ST_IDLE: begin
                // busy_r still set here means the post-RESUME cycle: not accepting.
                if (trigger && !busy_r) begin
                    issue_s = 1'b1;
                    nxt_b_s = FREEZE_B;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_FREEZE: begin
                if (complete_s) begin
                    issue_s = 1'b1;
                    nxt_a_s = {30'd0, CNT_CYCLES};
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_RD0: begin
                if (complete_s) begin
                    issue_s = 1'b1;
                    nxt_a_s = {30'd0, CNT_STALL};
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_RD1: begin
                if (complete_s) begin
                    issue_s = 1'b1;
                    nxt_a_s = {30'd0, CNT_BUSIDLE};
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_RD2: begin
                if (complete_s) begin
                    issue_s = 1'b1;
                    nxt_a_s = {30'd0, CNT_USER};
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_RD3: begin
                if (complete_s) begin
                    issue_s = 1'b1;
                    nxt_b_s = RESUME_B;
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
    end

    // Sequencing FSM, status flags and snapshot register file.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            snap_valid_r  <= 1'b0;
            err_timeout_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap_r[i] <= 32'd0;
            end
        end else if (abort_s) begin
            // Entries already read are kept; the counters stay frozen.
            state_r       <= ST_ABORT;
            err_timeout_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (trigger && !busy_r) begin
                        state_r       <= ST_FREEZE;
                        busy_r        <= 1'b1;
                        snap_valid_r  <= 1'b0;
                        err_timeout_r <= 1'b0;
                    end else if (busy_r) begin
                        // Return cycle after RESUME: publish the snapshot.
                        busy_r       <= 1'b0;
                        snap_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FREEZE: begin
                    if (complete_s) begin
                        state_r <= ST_RD0;
                    end else begin
                        state_r <= ST_FREEZE;
                    end
                end
                ST_RD0: begin
                    if (complete_s) begin
                        snap_r[CNT_CYCLES] <= ciResult;
                        state_r            <= ST_RD1;
                    end else begin
                        state_r <= ST_RD0;
                    end
                end
                ST_RD1: begin
                    if (complete_s) begin
                        snap_r[CNT_STALL] <= ciResult;
                        state_r           <= ST_RD2;
                    end else begin
                        state_r <= ST_RD1;
                    end
                end
                ST_RD2: begin
                    if (complete_s) begin
                        snap_r[CNT_BUSIDLE] <= ciResult;
                        state_r             <= ST_RD3;
                    end else begin
                        state_r <= ST_RD2;
                    end
                end
                ST_RD3: begin
                    if (complete_s) begin
                        snap_r[CNT_USER] <= ciResult;
                        state_r          <= ST_RESUME;
                    end else begin
                        state_r <= ST_RD3;
                    end
                end
                ST_RESUME: begin
                    if (complete_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESUME;
                    end
                end
                ST_ABORT: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_profile_snapshot_initiator.sv
// ---------------------------------------------------------------------------
// tb_profile_snapshot_initiator
// Directed bench: a small profile-counter responder with programmable done
// latency drives ciDone/ciResult; each scenario checks the start/operand
// timeline cycle by cycle plus the status flags and snapshot contents.
// ---------------------------------------------------------------------------
module tb_profile_snapshot_initiator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        trigger = 1'b0;
    logic        ciStart;
    logic [7:0]  ciCin;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        busy;
    logic        snapValid;
    logic [1:0]  snapIndex = 2'd0;
    logic [31:0] snapData;
    logic        errTimeout;

`ifdef SNAP_CLEAR_EN
    localparam logic [31:0] RESUME_EXP = 32'h00000F0F;
`else
    localparam logic [31:0] RESUME_EXP = 32'h0000000F;
`endif

    profile_snapshot_initiator dut (
        .clock      (clock),
        .reset      (reset),
        .trigger    (trigger),
        .ciStart    (ciStart),
        .ciCin      (ciCin),
        .ciValueA   (ciValueA),
        .ciValueB   (ciValueB),
        .ciDone     (ciDone),
        .ciResult   (ciResult),
        .busy       (busy),
        .snapValid  (snapValid),
        .snapIndex  (snapIndex),
        .snapData   (snapData),
        .errTimeout (errTimeout)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int starts = 0;
    int freezes = 0;

    // Responder model
    int          lat = 0;
    bit          hang_en = 1'b0;
    bit          spurious = 1'b0;
    logic [31:0] vals [4];
    logic        pend_r;
    int          wait_r;
    logic [1:0]  sel_r;
    logic [1:0]  sel_now_s;
    int          wait_now_s;
    logic        hang_now_s;

    always_comb begin
        sel_now_s  = ciStart ? ciValueA[1:0] : sel_r;
        wait_now_s = ciStart ? lat : wait_r;
        hang_now_s = ciStart && hang_en && (ciValueA == 32'd2) && (ciValueB == 32'd0);
        ciDone     = spurious | ((ciStart | pend_r) && (wait_now_s == 0) && !hang_now_s);
        ciResult   = vals[sel_now_s];
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_r <= 1'b0;
            wait_r <= 0;
            sel_r  <= 2'd0;
        end else if (ciStart) begin
            sel_r  <= ciValueA[1:0];
            pend_r <= (lat != 0);
            wait_r <= lat - 1;
        end else if (pend_r) begin
            if (wait_r == 0) pend_r <= 1'b0;
            else wait_r <= wait_r - 1;
        end
    end

    always @(negedge clock) begin
        if (ciStart) begin
            starts <= starts + 1;
            if (ciValueB == 32'h000000F0) freezes <= freezes + 1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_a(input int j);
        if (j >= 1 && j <= 4) return 32'(j - 1);
        else return 32'd0;
    endfunction

    function automatic logic [31:0] exp_b(input int j);
        if (j == 0) return 32'h000000F0;
        else if (j == 5) return RESUME_EXP;
        else return 32'd0;
    endfunction

    task automatic check_entries(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < 4; i++) begin
            snapIndex = 2'(i);
            #1;
            check_vec($sformatf("%s entry%0d", tag, i), snapData, e[i]);
        end
    endtask

    // Full sequence with done latency l; retrig holds trigger high while busy.
    task automatic run_seq(input string tag, input int l, input bit retrig,
                           input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3);
        int len;
        int j;
        len = l + 1;
        lat = l;
        vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
        @(negedge clock);
        trigger = 1'b1;
        for (int k = 1; k <= 6 * len + 2; k++) begin
            @(negedge clock);
            trigger = retrig && (k <= 6 * len + 1);
            if (k == 1) begin
                check_vec({tag, " err cleared"}, 32'(errTimeout), 32'd0);
                check_vec({tag, " valid cleared"}, 32'(snapValid), 32'd0);
            end
            if (k <= 6 * len) begin
                j = (k - 1) / len;
                check_vec($sformatf("%s start k%0d", tag, k), 32'(ciStart), 32'(((k - 1) % len) == 0));
                check_vec($sformatf("%s A k%0d", tag, k), ciValueA, exp_a(j));
                check_vec($sformatf("%s B k%0d", tag, k), ciValueB, exp_b(j));
                check_vec($sformatf("%s busy k%0d", tag, k), 32'(busy), 32'd1);
            end else if (k == 6 * len + 1) begin
                check_vec({tag, " busy tail"}, 32'(busy), 32'd1);
                check_vec({tag, " valid tail"}, 32'(snapValid), 32'd0);
                check_vec({tag, " no start tail"}, 32'(ciStart), 32'd0);
            end else begin
                check_vec({tag, " busy end"}, 32'(busy), 32'd0);
                check_vec({tag, " valid end"}, 32'(snapValid), 32'd1);
                check_vec({tag, " no start end"}, 32'(ciStart), 32'd0);
            end
        end
        trigger = 1'b0;
        check_entries(tag, v0, v1, v2, v3);
    endtask

    int s0;
    int f0;

    initial begin
        vals[0] = 32'd0; vals[1] = 32'd0; vals[2] = 32'd0; vals[3] = 32'd0;

        // Reset state
        #2;
        check_vec("rst start", 32'(ciStart), 32'd0);
        check_vec("rst cin", 32'(ciCin), 32'h00);
        check_vec("rst A", ciValueA, 32'd0);
        check_vec("rst B", ciValueB, 32'd0);
        check_vec("rst busy", 32'(busy), 32'd0);
        check_vec("rst valid", 32'(snapValid), 32'd0);
        check_vec("rst err", 32'(errTimeout), 32'd0);
        check_entries("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // 1: zero-wait responder
        run_seq("t1", 0, 1'b0, 32'd100, 32'd20, 32'd7, 32'd3);

        // 2: three-cycle done latency
        run_seq("t2", 3, 1'b0, 32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003);

        // 3: responder never answers RD2, timeout after 16 cycles
        lat = 0;
        hang_en = 1'b1;
        vals[0] = 32'h12345678; vals[1] = 32'h0BADF00D; vals[2] = 32'h55555555; vals[3] = 32'h66666666;
        @(negedge clock);
        trigger = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clock);
            trigger = 1'b0;
            check_vec($sformatf("t3 start k%0d", k), 32'(ciStart), 32'(k <= 4));
            check_vec($sformatf("t3 err k%0d", k), 32'(errTimeout), 32'(k >= 20));
            check_vec($sformatf("t3 busy k%0d", k), 32'(busy), 32'(k <= 20));
            check_vec($sformatf("t3 valid k%0d", k), 32'(snapValid), 32'd0);
        end
        hang_en = 1'b0;
        check_entries("t3", 32'h12345678, 32'h0BADF00D, 32'hA5A50002, 32'hA5A50003);

        // 4: spurious done in IDLE, then triggers held high while busy
        s0 = starts;
        f0 = freezes;
        @(negedge clock);
        spurious = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_vec("t4 spurious start", 32'(ciStart), 32'd0);
            check_vec("t4 spurious busy", 32'(busy), 32'd0);
            check_vec("t4 err sticky", 32'(errTimeout), 32'd1);
        end
        spurious = 1'b0;
        run_seq("t4", 1, 1'b1, 32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044);
        @(negedge clock);
        check_vec("t4 start count", 32'(starts - s0), 32'd6);
        check_vec("t4 seq count", 32'(freezes - f0), 32'd1);

        // 5: reset during the RD1 wait
        lat = 5;
        vals[0] = 32'hDEAD0000; vals[1] = 32'hDEAD0001; vals[2] = 32'hDEAD0002; vals[3] = 32'hDEAD0003;
        @(negedge clock);
        trigger = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            trigger = 1'b0;
        end
        check_vec("t5 in RD1 A", ciValueA, 32'd1);
        check_vec("t5 in RD1 busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_vec("t5 rst start", 32'(ciStart), 32'd0);
        check_vec("t5 rst A", ciValueA, 32'd0);
        check_vec("t5 rst B", ciValueB, 32'd0);
        check_vec("t5 rst busy", 32'(busy), 32'd0);
        check_vec("t5 rst valid", 32'(snapValid), 32'd0);
        check_vec("t5 rst err", 32'(errTimeout), 32'd0);
        check_entries("t5 rst", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_seq("t5", 0, 1'b0, 32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
